reduce_tree_pipe: RTL and testbench



---
 rtl/reduce_pkg.sv | 28 ++
 rtl/reduce_level.sv | 33 +++
 rtl/reduce_tree_pipe.sv | 114 +++++++++++
 tb/tb_reduce_tree_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reduce_pkg
// Brief    : Shared types and stage-count helpers for the reduction tree pipe.
// Revision : 1.0 - initial release
// ============================================================================
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'd0,
        MODE_AND = 2'd1,
        MODE_XOR = 2'd2,
        MODE_NOR = 2'd3
    } mode_t;

    function automatic int level_count(input int width);
        return $clog2(width);
    endfunction

    // The last stage absorbs the remainder when the levels do not divide evenly.
    function automatic int stage_count(input int width, input int levels_per_reg);
        int lvls;
        lvls = $clog2(width);
        return (lvls + levels_per_reg - 1) / levels_per_reg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_level.sv
`default_nettype none
// ============================================================================
// Module   : reduce_level
// Brief    : One combinational 2:1 level of the reduction tree.
// Revision : 1.0 - initial release
// ============================================================================
module reduce_level
    import reduce_pkg::*;
#(
    parameter int IN_W        = 2,
    parameter bit FINAL_LEVEL = 1'b0
) (
    input  logic [IN_W-1:0]   i_lvl_in,
    input  mode_t             i_mode,
    output logic [IN_W/2-1:0] o_lvl_out
);

    // NOR runs as an OR tree; only the root level applies the inversion.
    always_comb begin
        o_lvl_out = '0;
        for (int i = 0; i < IN_W / 2; i++) begin
            case (i_mode)
                MODE_AND: o_lvl_out[i] = i_lvl_in[2*i] & i_lvl_in[2*i+1];
                MODE_XOR: o_lvl_out[i] = i_lvl_in[2*i] ^ i_lvl_in[2*i+1];
                MODE_NOR: o_lvl_out[i] = FINAL_LEVEL ? ~(i_lvl_in[2*i] | i_lvl_in[2*i+1])
                                                     :  (i_lvl_in[2*i] | i_lvl_in[2*i+1]);
                default:  o_lvl_out[i] = i_lvl_in[2*i] | i_lvl_in[2*i+1];
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/reduce_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reduce_tree_pipe
// Brief    : Pipelined OR/AND/XOR/NOR reduction tree with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int LEVELS_PER_REG = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  mode_t            in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output mode_t            out_mode
);

    localparam int c_levels = level_count(WIDTH);
    localparam int c_stages = stage_count(WIDTH, LEVELS_PER_REG);

    // A single global stall freezes every stage; bubbles only vanish at the output.
    logic w_stall;
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    for (genvar s = 0; s < c_stages; s++) begin : g_stage
        localparam int c_first = s * LEVELS_PER_REG;
        localparam int c_last  = ((s + 1) * LEVELS_PER_REG < c_levels) ?
                                 ((s + 1) * LEVELS_PER_REG - 1) : (c_levels - 1);
        localparam int c_nlv   = c_last - c_first + 1;
        localparam int c_in_w  = WIDTH >> c_first;
        localparam int c_out_w = WIDTH >> (c_last + 1);

        logic [c_in_w-1:0]  w_data_in;
        mode_t              w_mode_in;
        logic               w_valid_in;

        logic [c_out_w-1:0] data_d;
        logic [c_out_w-1:0] data_q;
        mode_t              mode_d;
        mode_t              mode_q;
        logic               valid_d;
        logic               valid_q;

        if (s == 0) begin : g_from_port
            assign w_data_in  = in_data;
            assign w_mode_in  = in_mode;
            assign w_valid_in = in_valid;
        end else begin : g_from_stage
            assign w_data_in  = g_stage[s-1].data_q;
            assign w_mode_in  = g_stage[s-1].mode_q;
            assign w_valid_in = g_stage[s-1].valid_q;
        end

        for (genvar k = 0; k < c_nlv; k++) begin : g_lvl
            localparam int c_lw = c_in_w >> k;

            logic [c_lw-1:0]   w_in;
            logic [c_lw/2-1:0] w_out;

            if (k == 0) begin : g_head
                assign w_in = w_data_in;
            end else begin : g_chain
                assign w_in = g_lvl[k-1].w_out;
            end

            reduce_level #(
                .IN_W        (c_lw),
                .FINAL_LEVEL (c_first + k == c_levels - 1)
            ) u_level (
                .i_lvl_in  (w_in),
                .i_mode    (w_mode_in),
                .o_lvl_out (w_out)
            );
        end

        // Bubbles are loaded as all-zero so a dead slot never carries stale data.
        always_comb begin
            data_d  = data_q;
            mode_d  = mode_q;
            valid_d = valid_q;
            if (!w_stall) begin
                valid_d = w_valid_in;
                data_d  = w_valid_in ? g_lvl[c_nlv-1].w_out : '0;
                mode_d  = w_valid_in ? w_mode_in : MODE_OR;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q  <= '0;
                mode_q  <= MODE_OR;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                mode_q  <= mode_d;
                valid_q <= valid_d;
            end
        end
    end

    assign out_valid = g_stage[c_stages-1].valid_q;
    assign out_bit   = g_stage[c_stages-1].data_q[0];
    assign out_mode  = g_stage[c_stages-1].mode_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduce_tree_pipe
// Brief    : Directed and randomised checks of reduce_tree_pipe at three sizes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduce_tree_pipe;
    import reduce_pkg::*;

    logic        clk;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready, out_bit;
    logic [63:0] in_data;
    mode_t       in_mode, out_mode;

    logic        in_valid8, in_ready8, out_valid8, out_bit8;
    logic [7:0]  in_data8;
    mode_t       in_mode8, out_mode8;

    logic        in_valid2, in_ready2, out_valid2, out_bit2;
    logic [1:0]  in_data2;
    mode_t       in_mode2, out_mode2;

    int n_cmp;
    int n_bad;

    reduce_tree_pipe #(.WIDTH(64), .LEVELS_PER_REG(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_bit(out_bit), .out_mode(out_mode)
    );

    reduce_tree_pipe #(.WIDTH(8), .LEVELS_PER_REG(2)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
        .out_ready(1'b1), .out_bit(out_bit8), .out_mode(out_mode8)
    );

    reduce_tree_pipe #(.WIDTH(2), .LEVELS_PER_REG(1)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_mode(in_mode2), .out_valid(out_valid2),
        .out_ready(1'b1), .out_bit(out_bit2), .out_mode(out_mode2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_bit(input logic [63:0] d, input mode_t m);
        case (m)
            MODE_OR:  return |d;
            MODE_AND: return &d;
            MODE_XOR: return ^d;
            default:  return ~|d;
        endcase
    endfunction

    logic [63:0] t_data [10];
    mode_t       t_mode [10];
    logic        t_exp  [10];
    mode_t       m_tbl  [4];
    logic        e_tbl  [4];

    logic        q_bit  [$];
    mode_t       q_mode [$];

    initial begin
        int sent, got, stall_n;
        logic acc;
        logic [63:0] rd;
        mode_t rm;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        in_valid = 0; in_data = '0; in_mode = MODE_OR; out_ready = 1'b1;
        in_valid8 = 0; in_data8 = '0; in_mode8 = MODE_OR;
        in_valid2 = 0; in_data2 = '0; in_mode2 = MODE_OR;

        t_data = '{64'h0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 64'h7, 64'h0,
                   64'h0000_0100_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5,
                   64'h0123_4567_89AB_CDEE};
        t_mode = '{MODE_OR, MODE_OR, MODE_AND, MODE_AND, MODE_XOR, MODE_XOR,
                   MODE_NOR, MODE_NOR, MODE_XOR, MODE_XOR};
        t_exp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        m_tbl  = '{MODE_OR, MODE_AND, MODE_XOR, MODE_NOR};
        e_tbl  = '{1'b0, 1'b0, 1'b0, 1'b1};

        cyc();
        cyc();
        reset = 1'b0;

        // Reset state on all three instances
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_mode", out_mode, MODE_OR);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_out_valid2", out_valid2, 0);

        // Zero operand in each mode, three-cycle latency
        for (int m = 0; m < 4; m++) begin
            in_valid = 1; in_data = '0; in_mode = m_tbl[m];
            cyc();
            in_valid = 0;
            cyc();
            chk("zero_early_valid", out_valid, 0);
            cyc();
            chk("zero_valid", out_valid, 1);
            chk("zero_bit", out_bit, e_tbl[m]);
            chk("zero_mode", out_mode, m_tbl[m]);
            cyc();
            chk("zero_after_valid", out_valid, 0);
        end

        // Back-to-back all-ones then one-hot in XOR and AND
        for (int p = 0; p < 2; p++) begin
            in_mode = (p == 0) ? MODE_XOR : MODE_AND;
            in_valid = 1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
            cyc();
            in_data = 64'h0000_0000_0000_0001;
            cyc();
            in_valid = 0;
            cyc();
            chk("b2b_first_valid", out_valid, 1);
            chk("b2b_first_bit", out_bit, (p == 0) ? 0 : 1);
            cyc();
            chk("b2b_second_valid", out_valid, 1);
            chk("b2b_second_bit", out_bit, (p == 0) ? 1 : 0);
            cyc();
            chk("b2b_drained", out_valid, 0);
        end

        // Ten-request stream with a four-cycle output stall
        sent = 0; got = 0; stall_n = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            out_ready = !(got >= 1 && stall_n < 4);
            in_valid  = (sent < 10);
            if (sent < 10) begin
                in_data = t_data[sent];
                in_mode = t_mode[sent];
            end
            #1;
            if (!out_ready) begin
                stall_n++;
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_hold_bit", out_bit, t_exp[got]);
                chk("stall_hold_mode", out_mode, t_mode[got]);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("stream_bit", out_bit, t_exp[got]);
                chk("stream_mode", out_mode, t_mode[got]);
                got++;
            end
            cyc();
            if (acc) sent++;
        end
        chk("stream_count", got, 10);
        chk("stream_stalls", stall_n, 4);
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("stream_no_extra", out_valid, 0);
        end

        // Reset with two requests in flight
        in_valid = 1; in_mode = MODE_OR; in_data = 64'h1;
        cyc();
        in_data = 64'h10;
        cyc();
        in_valid = 0;
        reset = 1;
        cyc();
        reset = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("midrst_quiet", out_valid, 0);
        end

        // Small widths: N=2 and N=1
        in_valid8 = 1; in_data8 = 8'h80; in_mode8 = MODE_OR;
        in_valid2 = 1; in_data2 = 2'b10; in_mode2 = MODE_NOR;
        cyc();
        in_valid8 = 0; in_valid2 = 0;
        chk("w2_valid", out_valid2, 1);
        chk("w2_bit", out_bit2, 0);
        chk("w2_mode", out_mode2, MODE_NOR);
        chk("w8_early_valid", out_valid8, 0);
        cyc();
        chk("w8_valid", out_valid8, 1);
        chk("w8_bit", out_bit8, 1);
        chk("w8_mode", out_mode8, MODE_OR);
        chk("w2_drained", out_valid2, 0);
        cyc();
        chk("w8_drained", out_valid8, 0);

        // Random traffic against a behavioural reference
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                in_data = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            in_mode   = mode_t'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                q_bit.push_back(ref_bit(in_data, in_mode));
                q_mode.push_back(in_mode);
            end
            if (out_valid && out_ready) begin
                if (q_bit.size() == 0) begin
                    chk("rand_unexpected_output", 1, 0);
                end else begin
                    rd = {63'd0, q_bit.pop_front()};
                    rm = q_mode.pop_front();
                    chk("rand_bit", out_bit, rd);
                    chk("rand_mode", out_mode, rm);
                end
            end
            cyc();
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 10 && q_bit.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                rd = {63'd0, q_bit.pop_front()};
                rm = q_mode.pop_front();
                chk("drain_bit", out_bit, rd);
                chk("drain_mode", out_mode, rm);
            end
            cyc();
        end
        chk("rand_leftover", q_bit.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
